digit_projector: RTL and testbench
==================================

DIGIT_PROJECTOR -- requirements
Module: digit_projector

Interface
REQ-001 Parameter H_MAX, default 1280, max active columns.
REQ-002 Parameter V_MAX, default 800, max active rows.
REQ-003 Parameter AW, default 11, coordinate/address width.
REQ-004 Parameter CW, default 11, histogram count width.
REQ-005 Parameters MAX_CSEG / MAX_RSEG, default 8 / 4, max stored column/row segments.
REQ-006 Parameters MIN_SEG / MARGIN, default 2 / 2, minimum run length and border padding.
REQ-007 Port clk, in, 1, clock. Reset is rst_n, asynchronous, active-low.
REQ-008 Port rst_n, in, 1, asynchronous active-low reset.
REQ-009 Ports frame_vsync, frame_de, pix, in, 1 each: video timing and monochrome pixel.
REQ-010 Ports xpos, ypos, in, AW each: coordinates of the current pixel.
REQ-011 Ports h_active, v_active, in, AW each: active width/height, at most H_MAX/V_MAX.
REQ-012 Port fg_pol, in, 1: the foreground pixel value.
REQ-013 Ports col_thr, row_thr, in, CW each: projection thresholds.
REQ-014 Port start, in, 1: single-cycle measurement request.
REQ-015 Ports cseg_addr / rseg_addr, in, AW: segment read addresses.
REQ-016 Ports cseg_data / rseg_data, out, 2*AW: {start,end}, 1-cycle read latency.
REQ-017 Ports num_col / num_row, out, 4: stored segment counts.
REQ-018 Ports ovf_col / ovf_row, out, 1: segment overflow flags.
REQ-019 Ports busy, done, valid, out, 1 each: status signals.

Function
REQ-020 A frame edge is the registered falling edge of frame_vsync.
REQ-021 FSM states are IDLE, CLEAR, WAIT, ACCUM, SCAN_C, SCAN_R, DONE; busy=1 in every state except IDLE.
REQ-022 IDLE goes to CLEAR on start; start outside IDLE is ignored.
REQ-023 CLEAR writes 0 to column and row histogram entries 0..max(h_active,v_active)-1, one entry per cycle, then goes to WAIT.
REQ-024 WAIT goes to ACCUM on the next frame edge; ACCUM goes to SCAN_C on the following frame edge, so exactly one full frame is accumulated.
REQ-025 In ACCUM, each frame_de cycle with pix==fg_pol increments col_hist[xpos] by read-modify-write with 2-cycle latency; a back-to-back same-address write shall be bypassed, never lost.
REQ-026 Row counts accumulate in a line register and are written to row_hist[ypos] on the frame_de falling edge.
REQ-027 All histogram counts saturate at 2^CW-1 and never wrap.
REQ-028 SCAN_C reads col_hist 0..h_active-1, one entry per cycle; a bin is 1 when count > col_thr.
REQ-029 A run opens at the 0->1 transition; a run still open at index h_active-1 closes there.
REQ-030 A run of length >= MIN_SEG is stored as {max(s-MARGIN,0), min(e+MARGIN,h_active-1)}; shorter runs are discarded.
REQ-031 SCAN_R repeats REQ-028..030 on row_hist using row_thr and v_active.
REQ-032 When a segment is accepted while MAX segments are already stored, it is dropped, the count holds at MAX, and ovf_* is set.
REQ-033 DONE pulses done for one cycle, sets valid=1, then returns to IDLE.
REQ-034 num_*, ovf_* and the segment RAMs hold until the next DONE; valid clears on start.
REQ-035 num_*, ovf_* and the segment RAMs update atomically at DONE, using shadow count registers.
REQ-036 frame_vsync edges during SCAN_C, SCAN_R or DONE are ignored.
REQ-037 Segment reads at an address >= num_* return 0.

Reset
REQ-038 rst_n low forces IDLE and drives busy, done, valid, num_*, ovf_* and the read-data registers to 0, including mid-operation.
REQ-039 Histogram RAM contents are not reset; CLEAR guarantees a zeroed histogram before use.

Verification
REQ-040 Scenario: 64x32 frame, fg_pol=0, black vertical bars at x=10..19 and x=40..49, col_thr=0, start -> num_col=2, cseg {8,21},{38,51}, done after CLEAR+2 frames+96 scan cycles.
REQ-041 Scenario: a bar 1 column wide, MIN_SEG=2 -> no column segment; with run touching x=0 and x=63 -> stored {0,..} and {..,63}, clamped.
REQ-042 Scenario: 10 column bars with MAX_CSEG=8 -> num_col=8, ovf_col=1, first 8 bars stored.
REQ-043 Scenario: col_thr=5, column with 5 fg pixels -> not foreground; column with 6 -> foreground.
REQ-044 Scenario: row with 3000 fg pixels, CW=11 -> row count reads 2047.
REQ-045 Scenario: rst_n pulsed mid-ACCUM, then start -> clean restart with correct results and no residue from the previous frame.
REQ-046 Scenario: start asserted while busy -> ignored, with no change to the results of the measurement in progress.

Source files
------------

// File: rtl/digit_projector_if.sv
// Video stream feeding the digit projector: frame timing, monochrome pixel and its coordinates.
interface digit_projector_if #(
  parameter int AW = 11
);
  logic          frame_vsync;
  logic          frame_de;
  logic          pix;
  logic [AW-1:0] xpos;
  logic [AW-1:0] ypos;

  modport master (output frame_vsync, frame_de, pix, xpos, ypos);
  modport slave  (input  frame_vsync, frame_de, pix, xpos, ypos);
endinterface

// File: rtl/digit_projector.sv
// Accumulates one frame of column/row foreground histograms, then thresholds them into
// padded {start,end} segments that are published atomically when the measurement completes.
module digit_projector #(
  parameter int H_MAX    = 1280,
  parameter int V_MAX    = 800,
  parameter int AW       = 11,
  parameter int CW       = 11,
  parameter int MAX_CSEG = 8,
  parameter int MAX_RSEG = 4,
  parameter int MIN_SEG  = 2,
  parameter int MARGIN   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  digit_projector_if.slave  vid,
  input  logic [AW-1:0]     h_active,
  input  logic [AW-1:0]     v_active,
  input  logic              fg_pol,
  input  logic [CW-1:0]     col_thr,
  input  logic [CW-1:0]     row_thr,
  input  logic              start,
  input  logic [AW-1:0]     cseg_addr,
  input  logic [AW-1:0]     rseg_addr,
  output logic [2*AW-1:0]   cseg_data,
  output logic [2*AW-1:0]   rseg_data,
  output logic [3:0]        num_col,
  output logic [3:0]        num_row,
  output logic              ovf_col,
  output logic              ovf_row,
  output logic              busy,
  output logic              done,
  output logic              valid
);
  localparam int HIW = (H_MAX > 1) ? $clog2(H_MAX) : 1;
  localparam int VIW = (V_MAX > 1) ? $clog2(V_MAX) : 1;
  localparam int CIW = (MAX_CSEG > 1) ? $clog2(MAX_CSEG) : 1;
  localparam int RIW = (MAX_RSEG > 1) ? $clog2(MAX_RSEG) : 1;
  localparam logic [AW:0]   H_LIM   = (AW+1)'(H_MAX);
  localparam logic [AW:0]   V_LIM   = (AW+1)'(V_MAX);
  localparam logic [AW:0]   MIN_LEN = (AW+1)'(MIN_SEG);
  localparam logic [AW:0]   PAD     = (AW+1)'(MARGIN);
  localparam logic [3:0]    CMAX    = 4'(MAX_CSEG);
  localparam logic [3:0]    RMAX    = 4'(MAX_RSEG);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, CLEAR, WAIT, ACCUM, SCAN_C, SCAN_R, DONE} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          vs_q, de_q;
  logic [AW-1:0] y_q;
  logic [CW-1:0] line_q;
  logic          p1_v_q, p2_v_q;
  logic [AW-1:0] p1_a_q, p2_a_q;
  logic [CW-1:0] p1_rd_q, p2_val_q;
  logic          in_run_q;
  logic [AW-1:0] run_s_q;
  logic [3:0]    ccnt_q, rcnt_q, num_col_q, num_row_q;
  logic          covf_q, rovf_q, ovf_col_q, ovf_row_q, valid_q, bank_q;
  logic [2*AW-1:0] cseg_data_q, rseg_data_q;

  logic [CW-1:0]   col_hist [H_MAX];
  logic [CW-1:0]   row_hist [V_MAX];
  logic [2*AW-1:0] cseg_mem [2][MAX_CSEG];
  logic [2*AW-1:0] rseg_mem [2][MAX_RSEG];

  logic          frame_edge, hit, de_fall, clr_end;
  logic [AW-1:0] clr_lim;
  logic [AW:0]   idx_nx;
  logic [CW-1:0] acc_base, acc_sum;

  assign frame_edge = vs_q & ~vid.frame_vsync;
  assign hit        = (state_q == ACCUM) && vid.frame_de && (vid.pix == fg_pol);
  assign de_fall    = (state_q == ACCUM) && de_q && !vid.frame_de;
  assign clr_lim    = (h_active > v_active) ? h_active : v_active;
  assign idx_nx     = {1'b0, idx_q} + (AW+1)'(1);
  assign clr_end    = idx_nx >= {1'b0, clr_lim};

  // Read-modify-write with a one-deep bypass: a write to the same bin still in flight wins.
  assign acc_base = (p2_v_q && (p2_a_q == p1_a_q)) ? p2_val_q : p1_rd_q;
  assign acc_sum  = (acc_base == CNT_MAX) ? acc_base : acc_base + CW'(1);

  logic          scan_col, scan_on, scan_last, bin, run_open, run_close, seg_ok;
  logic [AW-1:0] scan_lim, run_s, run_e, seg_lo, seg_hi;
  logic [CW-1:0] bin_cnt;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    scan_col = (state_q == SCAN_C);
    scan_on  = scan_col || (state_q == SCAN_R);
    scan_lim = scan_col ? h_active : v_active;
    bin_cnt  = '0;
    if (scan_col && ({1'b0, idx_q} < H_LIM))
      bin_cnt = col_hist[idx_q[HIW-1:0]];
    else if (!scan_col && ({1'b0, idx_q} < V_LIM))
      bin_cnt = row_hist[idx_q[VIW-1:0]];
    bin       = scan_on && (bin_cnt > (scan_col ? col_thr : row_thr));
    scan_last = idx_nx >= {1'b0, scan_lim};
    run_open  = bin && !in_run_q;
    run_s     = run_open ? idx_q : run_s_q;
    run_e     = bin ? idx_q : idx_q - AW'(1);
    run_close = scan_on && ((bin && scan_last) || (!bin && in_run_q));
    seg_ok    = run_close && (({1'b0, run_e} - {1'b0, run_s} + (AW+1)'(1)) >= MIN_LEN);
    seg_lo    = ({1'b0, run_s} >= PAD) ? AW'({1'b0, run_s} - PAD) : '0;
    seg_hi    = (({1'b0, run_e} + PAD) >= {1'b0, scan_lim}) ? scan_lim - AW'(1)
                                                             : AW'({1'b0, run_e} + PAD);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE:   if (start) begin state_d = CLEAR; idx_d = '0; end
      CLEAR:  begin
                idx_d = AW'(idx_nx);
                if (clr_end) begin state_d = WAIT; idx_d = '0; end
              end
      WAIT:   if (frame_edge) state_d = ACCUM;
      ACCUM:  if (frame_edge) state_d = SCAN_C;
      SCAN_C: begin
                idx_d = AW'(idx_nx);
                if (scan_last) begin state_d = SCAN_R; idx_d = '0; end
              end
      SCAN_R: begin
                idx_d = AW'(idx_nx);
                if (scan_last) begin state_d = DONE; idx_d = '0; end
              end
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;      idx_q <= '0;
      vs_q <= 1'b0;         de_q <= 1'b0;       y_q <= '0;      line_q <= '0;
      p1_v_q <= 1'b0;       p1_a_q <= '0;       p2_v_q <= 1'b0; p2_a_q <= '0; p2_val_q <= '0;
      in_run_q <= 1'b0;     run_s_q <= '0;
      ccnt_q <= '0;         rcnt_q <= '0;       covf_q <= 1'b0; rovf_q <= 1'b0;
      num_col_q <= '0;      num_row_q <= '0;    ovf_col_q <= 1'b0; ovf_row_q <= 1'b0;
      valid_q <= 1'b0;      bank_q <= 1'b0;
      cseg_data_q <= '0;    rseg_data_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      vs_q     <= vid.frame_vsync;
      de_q     <= vid.frame_de;
      if (vid.frame_de) y_q <= vid.ypos;
      p1_v_q   <= hit && ({1'b0, vid.xpos} < H_LIM);
      p1_a_q   <= vid.xpos;
      p2_v_q   <= p1_v_q;
      p2_a_q   <= p1_a_q;
      p2_val_q <= acc_sum;

      if (state_q == CLEAR || de_fall) line_q <= '0;
      else if (hit && line_q != CNT_MAX) line_q <= line_q + CW'(1);

      if (state_q == IDLE && start) begin
        valid_q <= 1'b0;  in_run_q <= 1'b0;
        ccnt_q  <= '0;    rcnt_q   <= '0;   covf_q <= 1'b0; rovf_q <= 1'b0;
      end
      if (scan_on) begin
        if (run_close)     in_run_q <= 1'b0;
        else if (run_open) in_run_q <= 1'b1;
        if (run_open) run_s_q <= idx_q;
      end
      if (seg_ok && scan_col) begin
        if (ccnt_q < CMAX) ccnt_q <= ccnt_q + 4'd1;
        else               covf_q <= 1'b1;
      end
      if (seg_ok && !scan_col) begin
        if (rcnt_q < RMAX) rcnt_q <= rcnt_q + 4'd1;
        else               rovf_q <= 1'b1;
      end
      if (state_q == DONE) begin
        bank_q    <= ~bank_q;
        num_col_q <= ccnt_q;  num_row_q <= rcnt_q;
        ovf_col_q <= covf_q;  ovf_row_q <= rovf_q;
        valid_q   <= 1'b1;
      end

      cseg_data_q <= ({1'b0, cseg_addr} < (AW+1)'(num_col_q)) ? cseg_mem[bank_q][cseg_addr[CIW-1:0]] : '0;
      rseg_data_q <= ({1'b0, rseg_addr} < (AW+1)'(num_row_q)) ? rseg_mem[bank_q][rseg_addr[RIW-1:0]] : '0;
    end
  end

  // NOTE: storage arrays carry no reset; CLEAR zeroes the histograms and count registers gate segment reads.
  always_ff @(posedge clk) begin
    p1_rd_q <= col_hist[vid.xpos[HIW-1:0]];
    if (state_q == CLEAR && ({1'b0, idx_q} < H_LIM)) col_hist[idx_q[HIW-1:0]] <= '0;
    else if (p1_v_q)                                  col_hist[p1_a_q[HIW-1:0]] <= acc_sum;
    if (state_q == CLEAR && ({1'b0, idx_q} < V_LIM)) row_hist[idx_q[VIW-1:0]] <= '0;
    else if (de_fall && ({1'b0, y_q} < V_LIM))        row_hist[y_q[VIW-1:0]] <= line_q;
    if (seg_ok && scan_col && ccnt_q < CMAX)  cseg_mem[~bank_q][ccnt_q[CIW-1:0]] <= {seg_lo, seg_hi};
    if (seg_ok && !scan_col && rcnt_q < RMAX) rseg_mem[~bank_q][rcnt_q[RIW-1:0]] <= {seg_lo, seg_hi};
  end

  assign cseg_data = cseg_data_q;
  assign rseg_data = rseg_data_q;
  assign num_col   = num_col_q;
  assign num_row   = num_row_q;
  assign ovf_col   = ovf_col_q;
  assign ovf_row   = ovf_row_q;
  assign valid     = valid_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
endmodule

// File: tb/tb_digit_projector.sv
// Directed bench for digit_projector: a 64x32 video source, a software projection model and
// queues of expected segments compared against the segment read ports.
module tb_digit_projector;
  localparam int AW   = 11;
  localparam int CW   = 11;
  localparam int HA   = 64;
  localparam int VA   = 32;
  localparam int MAXC = 8;
  localparam int MAXR = 4;
  localparam int SAT  = 2047;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [AW-1:0]   h_active, v_active, cseg_addr, rseg_addr;
  logic            fg_pol, start;
  logic [CW-1:0]   col_thr, row_thr;
  logic [2*AW-1:0] cseg_data, rseg_data;
  logic [3:0]      num_col, num_row;
  logic            ovf_col, ovf_row, busy, done, valid;

  digit_projector_if #(.AW(AW)) vid ();

  digit_projector #(.AW(AW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .vid(vid),
    .h_active(h_active), .v_active(v_active), .fg_pol(fg_pol),
    .col_thr(col_thr), .row_thr(row_thr), .start(start),
    .cseg_addr(cseg_addr), .rseg_addr(rseg_addr),
    .cseg_data(cseg_data), .rseg_data(rseg_data),
    .num_col(num_col), .num_row(num_row), .ovf_col(ovf_col), .ovf_row(ovf_row),
    .busy(busy), .done(done), .valid(valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int colh [HA];
  bit rowfull [VA];
  bit long_rows;
  int mcol [HA];
  int mrow [VA];
  logic [2*AW-1:0] cq [$];
  logic [2*AW-1:0] rq [$];
  int lat;

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: cycle limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_pattern();
    for (int i = 0; i < HA; i++) colh[i] = 0;
    for (int i = 0; i < VA; i++) rowfull[i] = 1'b0;
    long_rows = 1'b0;
  endtask

  task automatic vsync_pulse();
    vid.frame_vsync = 1'b1; tick(4);
    vid.frame_vsync = 1'b0;
  endtask

  // One frame: falling vsync edge, then VA lines; optionally updates the model counts.
  task automatic send_frame(input bit model, input int rst_line, input int start_line);
    int len, x, lc;
    bit fg;
    vsync_pulse(); tick(4);
    for (int y = 0; y < VA; y++) begin
      if (y == rst_line) begin rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(1); end
      if (y == start_line) begin start = 1'b1; tick(1); start = 1'b0; end
      len = (rowfull[y] && long_rows) ? 3000 : HA;
      lc = 0;
      for (int i = 0; i < len; i++) begin
        x  = long_rows ? (i / 2) % HA : i % HA;
        fg = (y < colh[x]) || rowfull[y];
        vid.frame_de = 1'b1;
        vid.xpos = AW'(x);
        vid.ypos = AW'(y);
        vid.pix  = fg ? fg_pol : ~fg_pol;
        if (model && fg) begin
          mcol[x] = (mcol[x] < SAT) ? mcol[x] + 1 : SAT;
          lc++;
        end
        tick(1);
      end
      vid.frame_de = 1'b0;
      if (model) mrow[y] = (lc < SAT) ? lc : SAT;
      tick(8);
    end
  endtask

  task automatic measure(input string tag, input int start_line, output int cycles);
    for (int i = 0; i < HA; i++) mcol[i] = 0;
    for (int i = 0; i < VA; i++) mrow[i] = 0;
    start = 1'b1; tick(1); start = 1'b0;
    check({tag, "_busy_after_start"}, busy, 1);
    check({tag, "_valid_clr_on_start"}, valid, 0);
    tick(80);
    send_frame(1'b1, -1, start_line);
    vsync_pulse();
    cycles = 0;
    while (!done && cycles < 400) begin tick(1); cycles++; end
    check({tag, "_done_seen"}, done, 1);
    tick(1);
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_valid_set"}, valid, 1);
    check({tag, "_idle_after"}, busy, 0);
  endtask

  // Threshold a projection, find runs, pad/clamp and queue the segments that should be stored.
  task automatic model_scan(input bit is_col, input int thr, output int num, output bit ovf);
    int lim, maxs, s, e, c, lo, hi;
    bit inr, b;
    lim = is_col ? HA : VA;
    maxs = is_col ? MAXC : MAXR;
    s = 0; inr = 1'b0; num = 0; ovf = 1'b0;
    for (int i = 0; i < lim; i++) begin
      c = is_col ? mcol[i] : mrow[i];
      b = c > thr;
      if (b && !inr) begin inr = 1'b1; s = i; end
      if (inr && (!b || i == lim - 1)) begin
        e = b ? i : i - 1;
        inr = 1'b0;
        if (e - s + 1 >= 2) begin
          if (num < maxs) begin
            lo = (s >= 2) ? s - 2 : 0;
            hi = (e + 2 > lim - 1) ? lim - 1 : e + 2;
            if (is_col) cq.push_back({AW'(lo), AW'(hi)});
            else        rq.push_back({AW'(lo), AW'(hi)});
            num++;
          end else ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic verify(input string tag);
    int nc, nr;
    bit oc, orw;
    logic [2*AW-1:0] e;
    model_scan(1'b1, int'(col_thr), nc, oc);
    model_scan(1'b0, int'(row_thr), nr, orw);
    check({tag, "_num_col"}, num_col, nc);
    check({tag, "_ovf_col"}, ovf_col, oc);
    check({tag, "_num_row"}, num_row, nr);
    check({tag, "_ovf_row"}, ovf_row, orw);
    for (int i = 0; i <= MAXC; i++) begin
      cseg_addr = AW'(i); tick(1);
      e = (cq.size() > 0) ? cq.pop_front() : '0;
      check({tag, "_cseg"}, cseg_data, e);
    end
    for (int i = 0; i <= MAXR; i++) begin
      rseg_addr = AW'(i); tick(1);
      e = (rq.size() > 0) ? rq.pop_front() : '0;
      check({tag, "_rseg"}, rseg_data, e);
    end
  endtask

  initial begin
    h_active = AW'(HA); v_active = AW'(VA);
    fg_pol = 1'b0; col_thr = '0; row_thr = '0; start = 1'b0;
    cseg_addr = '0; rseg_addr = '0;
    vid.frame_vsync = 1'b0; vid.frame_de = 1'b0; vid.pix = 1'b0;
    vid.xpos = '0; vid.ypos = '0;
    clear_pattern();
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", valid, 0);
    check("rst_num_col", num_col, 0);
    check("rst_num_row", num_row, 0);
    check("rst_ovf_col", ovf_col, 0);
    check("rst_ovf_row", ovf_row, 0);
    check("rst_cseg_data", cseg_data, 0);
    check("rst_rseg_data", rseg_data, 0);
    rst_n = 1'b1; tick(2);

    // Two black bars on white, fg_pol=0; also checks edge-to-done latency.
    clear_pattern(); fg_pol = 1'b0; col_thr = '0; row_thr = '0;
    for (int x = 10; x < 20; x++) colh[x] = VA;
    for (int x = 40; x < 50; x++) colh[x] = VA;
    measure("bars", -1, lat);
    check("bars_scan_latency", lat, 97);
    verify("bars");

    // Single-column bar is discarded; runs touching both borders are clamped.
    clear_pattern(); fg_pol = 1'b1;
    for (int x = 0; x < 4; x++) colh[x] = VA;
    colh[30] = VA;
    for (int x = 60; x < HA; x++) colh[x] = VA;
    measure("edges", -1, lat);
    verify("edges");

    // Ten bars against eight column slots.
    clear_pattern(); fg_pol = 1'b1;
    for (int k = 0; k < 10; k++)
      for (int x = k * 6 + 1; x <= k * 6 + 3; x++) colh[x] = VA;
    measure("ovf", -1, lat);
    verify("ovf");

    // Threshold boundary: 5 pixels is not above col_thr=5, 6 pixels is.
    clear_pattern(); fg_pol = 1'b0; col_thr = CW'(5); row_thr = CW'(3);
    colh[20] = 5; colh[21] = 5; colh[30] = 6; colh[31] = 6;
    measure("thr", -1, lat);
    verify("thr");

    // Two 3000-pixel rows saturate the row count; paired x repeats exercise the bypass.
    clear_pattern(); fg_pol = 1'b1; col_thr = CW'(94); row_thr = CW'(2000);
    rowfull[5] = 1'b1; rowfull[6] = 1'b1; long_rows = 1'b1;
    measure("sat", -1, lat);
    verify("sat");

    // start pulsed mid-ACCUM must not disturb the measurement.
    clear_pattern(); fg_pol = 1'b1; col_thr = '0; row_thr = '0;
    for (int x = 5; x < 10; x++) colh[x] = VA;
    for (int x = 30; x < 36; x++) colh[x] = 20;
    measure("busy_start", 12, lat);
    verify("busy_start");

    // Reset mid-ACCUM with a full frame in progress, then a clean measurement.
    clear_pattern(); fg_pol = 1'b0;
    for (int x = 0; x < HA; x++) colh[x] = VA;
    start = 1'b1; tick(1); start = 1'b0;
    tick(80);
    send_frame(1'b0, 16, -1);
    check("midrst_busy", busy, 0);
    check("midrst_valid", valid, 0);
    check("midrst_num_col", num_col, 0);
    check("midrst_num_row", num_row, 0);
    clear_pattern(); fg_pol = 1'b0; col_thr = '0; row_thr = '0;
    for (int x = 20; x < 25; x++) colh[x] = VA;
    measure("restart", -1, lat);
    verify("restart");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
